// File: rtl/mastermind_round_ctrl.sv
// Round sequencer for the Mastermind codebreaker datapath.
// Detects guess presses, freezes the secret code once play starts,
// latches the guess, waits one settle cycle, captures the score and
// tracks the guess count and the win/loss outcome.
module mastermind_round_ctrl #(
    parameter int MAX_GUESSES = 10,
    parameter int CODE_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter,
    input  logic              real_game,
    input  logic [CODE_W-1:0] guess_in,
    input  logic [2:0]        correct_loc,
    input  logic [2:0]        value_only,
    output logic [CODE_W-1:0] guess_q,
    output logic              code_lock,
    output logic [2:0]        cl_q,
    output logic [2:0]        vo_q,
    output logic [6:0]        guesses,
    output logic              score_strobe,
    output logic              won,
    output logic              lost
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        LATCH = 3'd2,
        SCORE = 3'd3,
        WON   = 3'd4,
        LOST  = 3'd5
    } state_t;

    localparam logic [7:0] MAX_G   = 8'(MAX_GUESSES);
    localparam logic [6:0] SAT_CNT = 7'd99;

    state_t     state, state_nx;
    logic       enter_d;
    logic       press;
    logic       load_guess;
    logic       do_score;
    logic       set_won;
    logic       set_lost;
    logic [7:0] guesses_inc;
    logic [6:0] guesses_sat;

    // Rising edge of the already-synchronised key; a held key yields one press.
    assign press = enter & ~enter_d;

    // Count after this guess, wide enough to compare against the limit
    // without wrap, and the saturated value that is actually stored.
    assign guesses_inc = {1'b0, guesses} + 8'd1;
    assign guesses_sat = (guesses >= SAT_CNT) ? SAT_CNT : guesses + 7'd1;

    // Next-state logic and per-cycle datapath enables.
    always_comb begin
        state_nx   = state;
        load_guess = 1'b0;
        do_score   = 1'b0;
        set_won    = 1'b0;
        set_lost   = 1'b0;
        case (state)
            IDLE, PLAY: begin
                if (press) begin
                    load_guess = 1'b1;
                    state_nx   = LATCH;
                end
            end
            LATCH: begin
                // Comparators and sum network settle on guess_q this cycle.
                state_nx = SCORE;
            end
            SCORE: begin
                do_score = 1'b1;
                if (correct_loc >= 3'd4) begin
                    set_won  = 1'b1;
                    state_nx = WON;
                end else if (real_game && (guesses_inc >= MAX_G)) begin
                    set_lost = 1'b1;
                    state_nx = LOST;
                end else begin
                    state_nx = PLAY;
                end
            end
            WON:     state_nx = WON;
            LOST:    state_nx = LOST;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus registered outputs; reset wins over everything,
    // so a round interrupted in LATCH/SCORE never produces a score.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            enter_d      <= 1'b0;
            guess_q      <= '0;
            code_lock    <= 1'b0;
            cl_q         <= '0;
            vo_q         <= '0;
            guesses      <= '0;
            score_strobe <= 1'b0;
            won          <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state        <= state_nx;
            enter_d      <= enter;
            score_strobe <= do_score;
            if (load_guess) begin
                guess_q   <= guess_in;
                // First press freezes the generator; it stays frozen until reset.
                code_lock <= 1'b1;
            end
            if (do_score) begin
                cl_q    <= correct_loc;
                vo_q    <= value_only;
                guesses <= guesses_sat;
            end
            if (set_won)  won  <= 1'b1;
            if (set_lost) lost <= 1'b1;
        end
    end

endmodule
